// File: rtl/button_conditioner_if.sv
// Button bundle between the raw board pins and the conditioned pulse outputs.
// The slave side is the conditioner; the master side drives raw inputs and consumes pulses.
interface button_conditioner_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchronizer, stable-time debouncer and hold/auto-repeat timer.
// Every channel is an identical, independent copy of the same logic.
module button_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int REPEAT_DELAY    = 62500000,
    parameter int REPEAT_PERIOD   = 12500000
) (
    input  logic clk,
    input  logic rst,
    button_conditioner_if.slave bus
);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DW       = $clog2(DEBOUNCE_CYCLES);
    localparam int HW       = $clog2(HOLD_MAX);

    localparam logic [DW-1:0] DEB_TERM    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] DELAY_TERM  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PERIOD_TERM = HW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RELEASED,
        HOLD_WAIT,
        REPEATING
    } hold_state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic          sync_p0;
        logic          sync_p1;
        logic          lvl;
        logic [DW-1:0] dcnt;
        logic          press;
        logic          release_q;
        logic          repeat_q;
        logic          accept;
        logic          rise;
        logic          fall;
        hold_state_t   state;
        hold_state_t   state_nxt;
        logic [HW-1:0] hcnt;
        logic [HW-1:0] hcnt_nxt;
        logic          repeat_nxt;

        always_comb begin
            accept = (sync_p1 != lvl) && (dcnt == DEB_TERM);
            rise   = accept && sync_p1;
            fall   = accept && !sync_p1;
        end

        // Synchronizer stages and debouncer; press/release fire on the edge lvl updates.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_p0   <= 1'b0;
                sync_p1   <= 1'b0;
                lvl       <= 1'b0;
                dcnt      <= '0;
                press     <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync_p0   <= bus.btn_raw[i];
                sync_p1   <= sync_p0;
                press     <= rise;
                release_q <= fall;
                if (sync_p1 == lvl) begin
                    dcnt <= '0;
                end else if (accept) begin
                    lvl  <= sync_p1;
                    dcnt <= '0;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end

        // Hold timer; an accepted release overrides any repeat due in the same cycle.
        always_comb begin
            state_nxt  = state;
            hcnt_nxt   = hcnt;
            repeat_nxt = 1'b0;
            if (fall) begin
                state_nxt = RELEASED;
                hcnt_nxt  = '0;
            end else begin
                case (state)
                    RELEASED: begin
                        if (rise) begin
                            state_nxt = HOLD_WAIT;
                            hcnt_nxt  = '0;
                        end
                    end
                    HOLD_WAIT: begin
                        if (hcnt == DELAY_TERM) begin
                            repeat_nxt = 1'b1;
                            hcnt_nxt   = '0;
                            state_nxt  = REPEATING;
                        end else begin
                            hcnt_nxt = hcnt + 1'b1;
                        end
                    end
                    REPEATING: begin
                        if (hcnt == PERIOD_TERM) begin
                            repeat_nxt = 1'b1;
                            hcnt_nxt   = '0;
                        end else begin
                            hcnt_nxt = hcnt + 1'b1;
                        end
                    end
                    default: begin
                        state_nxt = RELEASED;
                        hcnt_nxt  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state    <= RELEASED;
                hcnt     <= '0;
                repeat_q <= 1'b0;
            end else begin
                state    <= state_nxt;
                hcnt     <= hcnt_nxt;
                repeat_q <= repeat_nxt;
            end
        end

        assign bus.btn_level[i]   = lvl;
        assign bus.btn_press[i]   = press;
        assign bus.btn_release[i] = release_q;
        assign bus.btn_repeat[i]  = repeat_q;
    end
endmodule
